// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the arbiter/sequencer that front-ends it.
// Holds the opcode encodings, the flag bit positions inside the 5-bit flag
// vector, and the sequencer FSM state encodings.
package alu_pkg;

  localparam logic [3:0] OP_ADD       = 4'd1;
  localparam logic [3:0] OP_ADD_CARRY = 4'd2;
  localparam logic [3:0] OP_SUB       = 4'd3;
  localparam logic [3:0] OP_INC       = 4'd4;
  localparam logic [3:0] OP_DEC       = 4'd5;
  localparam logic [3:0] OP_AND       = 4'd6;
  localparam logic [3:0] OP_NOT       = 4'd7;
  localparam logic [3:0] OP_ROL       = 4'd8;
  localparam logic [3:0] OP_ROR       = 4'd9;

  localparam int FLAG_CARRY   = 4;
  localparam int FLAG_BORROW  = 3;
  localparam int FLAG_ZERO    = 2;
  localparam int FLAG_PARITY  = 1;
  localparam int FLAG_INVALID = 0;
  localparam int NUM_FLAGS    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset (pointer -> requester 0)
//   en           : grants are only issued while en is high
//   req_valid    : per-requester request
//   grant        : one-hot grant (combinational from req_valid, en, pointer)
// Any grant is taken as an accept; the pointer then moves to the requester
// that was not granted, including when only one requester was valid.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req_valid,
  output logic [1:0] grant
);
  import alu_pkg::*;

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|grant) ptr_d = grant[0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational ALU between two
// requesters. One operation is in flight at a time: accept -> drive registered
// operands for one cycle -> capture result/flags -> hold response until taken.
//
// state | meaning
// IDLE  | waiting for a request; req_ready shows the arbiter grant
// EXEC  | alu_* registered, ALU settling; result captured at end of cycle
// RESP  | rsp_valid high, response held until rsp_ready
//
// Ports:
//   clk, reset_n             : clock, synchronous active-low reset
//   req_valid / req_ready    : per-requester request handshake
//   req{0,1}_*               : per-requester opcode, operands, carry in
//   alu_*                    : registered ALU inputs; alu_y/alu_flags back
//   rsp_valid / rsp_ready    : response handshake
//   rsp_id, rsp_y, rsp_flags : requester id, captured result and flags
module alu_arbiter #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [3:0]           req0_opcode,
  input  logic [BUS_WIDTH-1:0] req0_a,
  input  logic [BUS_WIDTH-1:0] req0_b,
  input  logic                 req0_carry_in,
  input  logic [3:0]           req1_opcode,
  input  logic [BUS_WIDTH-1:0] req1_a,
  input  logic [BUS_WIDTH-1:0] req1_b,
  input  logic                 req1_carry_in,
  output logic [3:0]           alu_opcode,
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  output logic                 alu_carry_in,
  input  logic [BUS_WIDTH-1:0] alu_y,
  input  logic [4:0]           alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [BUS_WIDTH-1:0] rsp_y,
  output logic [4:0]           rsp_flags
);
  import alu_pkg::*;

  state_e state_q;
  state_e state_d;

  logic       arb_en;
  logic [1:0] grant;
  logic       accept;

  logic [3:0]           alu_opcode_q, alu_opcode_d;
  logic [BUS_WIDTH-1:0] alu_a_q,      alu_a_d;
  logic [BUS_WIDTH-1:0] alu_b_q,      alu_b_d;
  logic                 alu_cin_q,    alu_cin_d;
  logic                 rsp_id_q,     rsp_id_d;
  logic [BUS_WIDTH-1:0] rsp_y_q,      rsp_y_d;
  logic [4:0]           rsp_flags_q,  rsp_flags_d;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (arb_en),
    .req_valid (req_valid),
    .grant     (grant)
  );

  assign accept = |(req_valid & grant);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    arb_en    = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    req_ready = grant;
  end

  // Datapath: operands captured on accept, result captured at end of EXEC.
  always_comb begin
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_cin_d    = alu_cin_q;
    rsp_id_d     = rsp_id_q;
    rsp_y_d      = rsp_y_q;
    rsp_flags_d  = rsp_flags_q;
    if (accept) begin
      rsp_id_d = grant[1];
      if (grant[1]) begin
        alu_opcode_d = req1_opcode;
        alu_a_d      = req1_a;
        alu_b_d      = req1_b;
        alu_cin_d    = req1_carry_in;
      end else begin
        alu_opcode_d = req0_opcode;
        alu_a_d      = req0_a;
        alu_b_d      = req0_b;
        alu_cin_d    = req0_carry_in;
      end
    end
    if (state_q == ST_EXEC) begin
      rsp_y_d     = alu_y;
      rsp_flags_d = alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= '0;
      rsp_flags_q  <= '0;
    end else begin
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_cin_q    <= alu_cin_d;
      rsp_id_q     <= rsp_id_d;
      rsp_y_q      <= rsp_y_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_opcode   = alu_opcode_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_carry_in = alu_cin_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_y        = rsp_y_q;
  assign rsp_flags    = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_opcode, req1_opcode;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_carry_in, req1_carry_in;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       alu_carry_in;
  logic [4:0] alu_flags;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_y;
  logic [4:0] rsp_flags;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.BUS_WIDTH(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req0_opcode   (req0_opcode),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req0_carry_in (req0_carry_in),
    .req1_opcode   (req1_opcode),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .req1_carry_in (req1_carry_in),
    .alu_opcode    (alu_opcode),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_carry_in  (alu_carry_in),
    .alu_y         (alu_y),
    .alu_flags     (alu_flags),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_y         (rsp_y),
    .rsp_flags     (rsp_flags)
  );

  // Behavioural ALU at the parent level: flags {carry, borrow, zero, parity, invalid}
  logic [8:0] sum9;
  logic       f_c, f_b, f_inv;
  always_comb begin
    sum9  = '0;
    alu_y = '0;
    f_c   = 1'b0;
    f_b   = 1'b0;
    f_inv = 1'b0;
    case (alu_opcode)
      4'd1: begin sum9 = 9'(alu_a) + 9'(alu_b); alu_y = sum9[7:0]; f_c = sum9[8]; end
      4'd2: begin sum9 = 9'(alu_a) + 9'(alu_b) + 9'(alu_carry_in); alu_y = sum9[7:0]; f_c = sum9[8]; end
      4'd3: begin alu_y = alu_a - alu_b; f_b = (alu_a < alu_b); end
      4'd4: begin sum9 = 9'(alu_a) + 9'd1; alu_y = sum9[7:0]; f_c = sum9[8]; end
      4'd5: begin alu_y = alu_a - 8'd1; f_b = (alu_a == 8'd0); end
      4'd6: alu_y = alu_a & alu_b;
      4'd7: alu_y = ~alu_a;
      4'd8: alu_y = {alu_a[6:0], alu_a[7]};
      4'd9: alu_y = {alu_a[0], alu_a[7:1]};
      default: f_inv = 1'b1;
    endcase
    alu_flags = {f_c, f_b, (alu_y == 8'd0), ^alu_y, f_inv};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int gid  [4];
  int gcyc [4];
  int ngr;
  int cyc;

  initial begin
    reset_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    req0_opcode = '0; req0_a = '0; req0_b = '0; req0_carry_in = 1'b0;
    req1_opcode = '0; req1_a = '0; req1_b = '0; req1_carry_in = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_cin", alu_carry_in, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_req_ready", req_ready, 0);
    reset_n = 1'b1;
    tick();

    // Single requester 0: ADD 9+33
    req0_opcode = 4'd1; req0_a = 8'd9; req0_b = 8'd33;
    req_valid = 2'b01;
    settle();
    chk("t1_req_ready_idle", req_ready, 2'b01);
    tick();
    chk("t1_req_ready_exec", req_ready, 2'b00);
    chk("t1_alu_opcode", alu_opcode, 1);
    chk("t1_alu_a", alu_a, 9);
    chk("t1_alu_b", alu_b, 33);
    chk("t1_rsp_valid_exec", rsp_valid, 0);
    req_valid = 2'b00;
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_y", rsp_y, 42);
    chk("t1_rsp_flags", rsp_flags, 5'b00010);
    tick();
    chk("t1_rsp_valid_drop", rsp_valid, 0);

    // Contention right after reset: requester 0 first, then 1
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req0_opcode = 4'd2; req0_a = 8'd9;  req0_b = 8'd33; req0_carry_in = 1'b1;
    req1_opcode = 4'd3; req1_a = 8'd65; req1_b = 8'd66; req1_carry_in = 1'b0;
    req_valid = 2'b11;
    settle();
    chk("t2_grant0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    tick();
    chk("t2_rsp0_valid", rsp_valid, 1);
    chk("t2_rsp0_id", rsp_id, 0);
    chk("t2_rsp0_y", rsp_y, 43);
    chk("t2_rsp0_flags", rsp_flags, 5'b00000);
    chk("t2_req_ready_resp", req_ready, 2'b00);
    tick();
    chk("t2_grant1", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t2_rsp1_valid", rsp_valid, 1);
    chk("t2_rsp1_id", rsp_id, 1);
    chk("t2_rsp1_y", rsp_y, 255);
    chk("t2_rsp1_flags", rsp_flags, 5'b01000);
    tick();

    // Continuous contention: alternate grants, 3 cycles apart
    req0_opcode = 4'd1; req0_a = 8'd1;    req0_b = 8'd2;
    req1_opcode = 4'd6; req1_a = 8'hF0;   req1_b = 8'h3C;
    req_valid = 2'b11;
    settle();
    ngr = 0;
    cyc = 0;
    for (int k = 0; k < 40 && ngr < 4; k++) begin
      if (req_ready != 2'b00) begin
        gid[ngr]  = int'(req_ready[1]);
        gcyc[ngr] = cyc;
        ngr++;
      end
      tick();
      cyc++;
    end
    req_valid = 2'b00;
    chk("t3_grant_count", ngr, 4);
    chk("t3_order0", gid[0], 0);
    chk("t3_order1", gid[1], 1);
    chk("t3_order2", gid[2], 0);
    chk("t3_order3", gid[3], 1);
    chk("t3_gap01", gcyc[1] - gcyc[0], 3);
    chk("t3_gap12", gcyc[2] - gcyc[1], 3);
    chk("t3_gap23", gcyc[3] - gcyc[2], 3);
    tick();
    tick();

    // Response stall: INC 0x7F with rsp_ready low for 5 cycles
    rsp_ready = 1'b0;
    req0_opcode = 4'd4; req0_a = 8'h7F; req0_b = 8'h00;
    req_valid = 2'b01;
    settle();
    chk("t4_grant", req_ready, 2'b01);
    tick();
    tick();
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_y", rsp_y, 8'h80);
    chk("t4_rsp_flags", rsp_flags, 5'b00010);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_stall_valid", rsp_valid, 1);
      chk("t4_stall_y", rsp_y, 8'h80);
      chk("t4_stall_flags", rsp_flags, 5'b00010);
      chk("t4_stall_ready", req_ready, 2'b00);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4_resume_ready", req_ready, 2'b01);
    chk("t4_resume_valid", rsp_valid, 0);
    req_valid = 2'b00;
    settle();
    tick();

    // Invalid opcode from requester 1
    req1_opcode = 4'd0; req1_a = 8'd5; req1_b = 8'd7;
    req_valid = 2'b10;
    settle();
    chk("t5_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    tick();
    chk("t5_inv_id", rsp_id, 1);
    chk("t5_inv_y", rsp_y, 0);
    chk("t5_inv_flags", rsp_flags, 5'b00101);
    tick();

    // DEC 0 from requester 1
    req1_opcode = 4'd5; req1_a = 8'd0; req1_b = 8'd0;
    req_valid = 2'b10;
    settle();
    tick();
    req_valid = 2'b00;
    tick();
    chk("t5_dec_id", rsp_id, 1);
    chk("t5_dec_y", rsp_y, 255);
    chk("t5_dec_flags", rsp_flags, 5'b01000);
    tick();

    // Reset during EXEC (pointer is at requester 1 just before reset)
    req0_opcode = 4'd1; req0_a = 8'd3; req0_b = 8'd4;
    req_valid = 2'b01;
    settle();
    tick();
    req_valid = 2'b00;
    chk("t6_in_exec_opcode", alu_opcode, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t6_alu_opcode", alu_opcode, 0);
    chk("t6_alu_a", alu_a, 0);
    chk("t6_alu_b", alu_b, 0);
    chk("t6_alu_cin", alu_carry_in, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_rsp_id", rsp_id, 0);
    chk("t6_rsp_y", rsp_y, 0);
    chk("t6_rsp_flags", rsp_flags, 0);
    tick();
    chk("t6_no_rsp_a", rsp_valid, 0);
    tick();
    chk("t6_no_rsp_b", rsp_valid, 0);

    req0_opcode = 4'd6; req0_a = 8'h11; req0_b = 8'h0F;
    req1_opcode = 4'd7; req1_a = 8'h22; req1_b = 8'h00;
    req_valid = 2'b11;
    settle();
    chk("t6_grant_after_rst", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    chk("t6_alu_a_after", alu_a, 8'h11);
    chk("t6_alu_opcode_after", alu_opcode, 6);
    tick();
    chk("t6_rsp_id_after", rsp_id, 0);
    chk("t6_rsp_y_after", rsp_y, 8'h01);
    chk("t6_rsp_flags_after", rsp_flags, 5'b00010);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
